// File: rtl/spram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : spram_pkg                                                      |
// | Purpose   : Geometry of the 16Kx16 SPRAM macro and the arbiter state       |
// |             encoding. Shared by the arbiter, the spram wrapper and the CPU.|
// | Contents  : SPRAM_WIDTH, SPRAM_DEPTH, SPRAM_ADDRW, SPRAM_WEW, arb_state_t  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package spram_pkg;

  localparam int SPRAM_WIDTH = 16;
  localparam int SPRAM_DEPTH = 16384;
  localparam int SPRAM_ADDRW = 14;
  localparam int SPRAM_WEW   = SPRAM_WIDTH / 4;  // one write-enable bit per nibble

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

endpackage : spram_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : rr_arbiter                                                     |
// | Purpose   : Purely combinational round-robin pick. Searches req_i starting |
// |             at ptr_i, ascending and wrapping modulo N; first set bit wins. |
// | Ports     : req_i   [N-1:0] request vector                                 |
// |             ptr_i   [1:0]   search start position (must be < N)            |
// |             gnt_o   [N-1:0] one-hot grant, all zero when no request        |
// |             idx_o   [1:0]   index of the winner (0 when no request)        |
// |             valid_o         a winner exists                                |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [1:0]   idx_o,
  output logic         valid_o
);

  // Outer loop walks the priority order (ptr, ptr+1, ...); the inner loop
  // maps that rotated position back onto a constant bit index so every
  // select stays static after unrolling.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!valid_o && req_i[j] && (j == ((int'(ptr_i) + k) % N))) begin
          valid_o  = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = 2'(j);
        end
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/spram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : spram_arbiter                                                  |
// | Purpose   : Shares one 16Kx16 SPRAM between NREQ requesters with           |
// |             round-robin arbitration, one access per cycle. Zero-fills the  |
// |             whole array after reset so the tape starts all-zero.           |
// | Ports     : clk, rst_n          clock, synchronous active-low reset        |
// |             req_i/req_we_i/req_addr_i/req_wdata_i  packed per requester    |
// |             gnt_o, rvalid_o     one-hot grant / read-data-valid            |
// |             rdata_o             shared read data (pass-through)            |
// |             init_done_o         fill complete, arbitration live            |
// |             mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i  SPRAM side        |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_i,
  input  logic [NREQ*SPRAM_WEW-1:0]     req_we_i,
  input  logic [NREQ*SPRAM_ADDRW-1:0]   req_addr_i,
  input  logic [NREQ*SPRAM_WIDTH-1:0]   req_wdata_i,
  output logic [NREQ-1:0]               gnt_o,
  output logic [NREQ-1:0]               rvalid_o,
  output logic [SPRAM_WIDTH-1:0]        rdata_o,
  output logic                          init_done_o,
  output logic [SPRAM_WEW-1:0]          mem_we_o,
  output logic [SPRAM_ADDRW-1:0]        mem_addr_o,
  output logic [SPRAM_WIDTH-1:0]        mem_wdata_o,
  input  logic [SPRAM_WIDTH-1:0]        mem_rdata_i
);

  arb_state_t               state_q, state_d;
  logic [SPRAM_ADDRW-1:0]   clr_addr_q, clr_addr_d;
  logic [1:0]               rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]          rvalid_q, rvalid_d;
  logic                     init_done_q;
  logic [SPRAM_ADDRW-1:0]   last_addr_q;

  logic [NREQ-1:0]          arb_gnt;
  logic [1:0]               arb_idx;
  logic                     arb_valid;

  logic [SPRAM_WEW-1:0]     win_we;
  logic [SPRAM_ADDRW-1:0]   win_addr;
  logic [SPRAM_WIDTH-1:0]   win_wdata;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Winner payload select; arb_gnt is one-hot so at most one slot matches.
  always_comb begin
    win_we    = '0;
    win_addr  = '0;
    win_wdata = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (arb_gnt[j]) begin
        win_we    = req_we_i[j*SPRAM_WEW +: SPRAM_WEW];
        win_addr  = req_addr_i[j*SPRAM_ADDRW +: SPRAM_ADDRW];
        win_wdata = req_wdata_i[j*SPRAM_WIDTH +: SPRAM_WIDTH];
      end
    end
  end

  // Next-state and SPRAM drive. With no request in RUN the address bus
  // parks on its previous value so the macro sees no needless toggling.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    rr_ptr_d    = rr_ptr_q;
    rvalid_d    = '0;
    gnt_o       = '0;
    mem_we_o    = '0;
    mem_addr_o  = last_addr_q;
    mem_wdata_o = '0;
    if (!rst_n) begin
      mem_addr_o = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          mem_we_o   = '1;
          mem_addr_o = clr_addr_q;
          clr_addr_d = clr_addr_q + 14'd1;
          if (clr_addr_q == SPRAM_ADDRW'(SPRAM_DEPTH - 1)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (arb_valid) begin
            gnt_o       = arb_gnt;
            mem_we_o    = win_we;
            mem_addr_o  = win_addr;
            mem_wdata_o = win_wdata;
            rr_ptr_d    = (arb_idx == 2'(NREQ - 1)) ? 2'd0 : arb_idx + 2'd1;
            // An all-zero nibble mask is a read; its data returns next cycle.
            if (win_we == '0) begin
              rvalid_d = arb_gnt;
            end
          end
        end
        default: begin
          state_d = ST_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_addr_q  <= '0;
      rr_ptr_q    <= '0;
      rvalid_q    <= '0;
      init_done_q <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rr_ptr_q    <= rr_ptr_d;
      rvalid_q    <= rvalid_d;
      init_done_q <= (state_d == ST_RUN);
      last_addr_q <= mem_addr_o;
    end
  end

  // Gating with rst_n drops a read whose data would land during reset.
  assign rvalid_o    = rvalid_q & {NREQ{rst_n}};
  assign rdata_o     = mem_rdata_i;
  assign init_done_o = init_done_q;

endmodule : spram_arbiter
`default_nettype wire
